// File: rtl/alu_registered.sv
// alu_registered: N-bit integer ALU (AND, OR, ADD, SUB, pass-B) with the
// result and zero flag captured in an output register. One cycle of latency,
// and a new operation can be accepted every cycle.
module alu_registered #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   alu_control,
   output logic         out_valid,
   output logic [N-1:0] result,
   output logic         zero
);

   // Operation codes understood by the decoder
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;

   logic [N-1:0] result_next;
   logic         zero_next;

   // Combinational operation decode; unknown codes produce 0
   always_comb begin
      result_next = '0;
      unique case (alu_control)
         OP_AND:  result_next = a & b;
         OP_OR:   result_next = a | b;
         OP_ADD:  result_next = a + b;   // carry-out dropped, wraps mod 2^N
         OP_SUB:  result_next = a - b;   // two's complement wrap
         OP_PASS: result_next = b;
         default: result_next = '0;
      endcase
   end

   // Zero flag is derived from the N-bit result, independent of operation
   assign zero_next = (result_next == '0);

   // Output register: load on in_valid, otherwise hold result/zero and drop out_valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= result_next;
            zero   <= zero_next;
         end
      end
   end

endmodule

// File: tb/tb_alu_registered.sv
// Self-checking bench for alu_registered: directed vectors, asynchronous
// reset mid-stream, randomized back-to-back stream and in_valid drop.
module tb_alu_registered;

   localparam int N = 64;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   alu_control;
   logic         out_valid;
   logic [N-1:0] result;
   logic         zero;

   int checks;
   int errors;

   logic [N-1:0] last_result;
   logic         last_zero;

   alu_registered #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .result      (result),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [N-1:0] observed,
                            input logic [N-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference model: plain unsigned arithmetic on the operation rules
   function automatic logic [N-1:0] model(input logic [3:0] op,
                                          input logic [N-1:0] x,
                                          input logic [N-1:0] y);
      logic [N:0] wide;
      case (op)
         4'd0: return x & y;
         4'd1: return x | y;
         4'd2: begin wide = {1'b0, x} + {1'b0, y}; return wide[N-1:0]; end
         4'd6: begin
            if (x >= y) return x - y;
            else begin
               wide = (({1'b1, {N{1'b0}}}) - {1'b0, y}) + {1'b0, x};
               return wide[N-1:0];
            end
         end
         4'd7: return y;
         default: return '0;
      endcase
   endfunction

   // Apply one operation at a negedge, check it at the following negedge
   task automatic do_op(input string tag, input logic [3:0] op,
                        input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] exp_res);
      alu_control = op;
      a           = x;
      b           = y;
      in_valid    = 1'b1;
      @(negedge clk);
      $display("op=%b a=%h b=%h result=%h zero=%0d out_valid=%0d",
               op, x, y, result, zero, out_valid);
      check_val({tag, "_result"}, result, exp_res);
      check_val({tag, "_zero"}, N'(zero), N'(exp_res == '0));
      check_val({tag, "_valid"}, N'(out_valid), N'(1));
      last_result = exp_res;
      last_zero   = (exp_res == '0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      alu_control = 4'd0;
      last_result = '0;
      last_zero   = 1'b1;

      repeat (2) @(negedge clk);
      check_val("rst_result", result, '0);
      check_val("rst_zero", N'(zero), N'(1));
      check_val("rst_valid", N'(out_valid), N'(0));
      reset = 1'b0;

      // Start a stream, then assert reset asynchronously between edges
      do_op("pre_rst", 4'b0010, 64'h1234, 64'h1111, 64'h2345);
      alu_control = 4'b0001;
      a           = 64'h00F0;
      b           = 64'h0F00;
      in_valid    = 1'b1;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      $display("async reset asserted mid-stream result=%h zero=%0d out_valid=%0d",
               result, zero, out_valid);
      check_val("async_rst_result", result, '0);
      check_val("async_rst_zero", N'(zero), N'(1));
      check_val("async_rst_valid", N'(out_valid), N'(0));
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors
      do_op("and_abc", 4'b0000, 64'hABC, 64'hDEF, 64'h8AC);
      do_op("and_1", 4'b0000, 64'h267B, 64'h3D8, 64'h258);
      do_op("and_0", 4'b0000, 64'h6D55, 64'h92AA, 64'h0);
      do_op("or_1", 4'b0001, 64'hA596, 64'h4EAA, 64'hEFBE);
      do_op("or_2", 4'b0001, 64'h4565, 64'hBA9A, 64'hFFFF);
      do_op("or_0", 4'b0001, 64'h0, 64'h0, 64'h0);
      do_op("add_1", 4'b0010, 64'h967B, 64'hC8A1, 64'h15F1C);
      do_op("add_2", 4'b0010, 64'hFFFF, 64'hFFFF, 64'h1FFFE);
      do_op("add_0", 4'b0010, 64'h0, 64'h0, 64'h0);
      do_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0);
      do_op("sub_1", 4'b0110, 64'h4589, 64'h32A2, 64'h12E7);
      do_op("sub_neg", 4'b0110, 64'h569B, 64'hB858, 64'hFFFF_FFFF_FFFF_9E43);
      do_op("sub_0", 4'b0110, 64'h0, 64'h0, 64'h0);
      do_op("pass_1", 4'b0111, 64'hD255, 64'h42A4, 64'h42A4);
      do_op("pass_0", 4'b0111, 64'h61BD, 64'h0, 64'h0);
      do_op("illegal", 4'b1111, 64'h1234, 64'h5678, 64'h0);

      // Randomized back-to-back stream against the reference model
      for (int i = 0; i < 15; i++) begin
         logic [3:0]   op;
         logic [N-1:0] x;
         logic [N-1:0] y;
         case ($urandom_range(0, 5))
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b0110;
            4: op = 4'b0111;
            default: op = 4'($urandom_range(8, 15));
         endcase
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         if (i == 3) y = x;   // forces a zero difference / equal-operand case
         do_op("rand", op, x, y, model(op, x, y));
      end

      // Drop in_valid: out_valid falls, result/zero hold despite new inputs
      for (int i = 0; i < 2; i++) begin
         in_valid    = 1'b0;
         alu_control = 4'b0010;
         a           = {$urandom, $urandom} | 64'h1;
         b           = 64'h5;
         @(negedge clk);
         $display("idle cycle result=%h zero=%0d out_valid=%0d",
                  result, zero, out_valid);
         check_val("idle_valid", N'(out_valid), N'(0));
         check_val("idle_result", result, last_result);
         check_val("idle_zero", N'(zero), N'(last_zero));
      end

      // Resume after the gap
      do_op("resume", 4'b0010, 64'h10, 64'h20, 64'h30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_registered.md
Name: alu_registered

Overview:
- Parameterised N-bit integer ALU for the single-cycle/pipelined datapath; computes AND, OR, ADD, SUB and pass-B on two operands, selected by a 4-bit control code.
- Result and zero flag are captured in an output register, so the block presents a clean registered boundary to the next pipeline stage.
- Sits between the register-file/immediate mux and the memory/writeback stage.

Parameters:
- N, 64, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and control are valid this cycle; capture them.
- a  input  N  operand A.
- b  input  N  operand B.
- alu_control  input  4  operation select.
- out_valid  output  1  result/zero hold a freshly computed value.
- result  output  N  registered ALU result.
- zero  output  1  registered flag, 1 when the captured result equals 0.

Behaviour:
- One clock domain. reset is asynchronous and active-high; clock and reset ports are named clk and reset.
- While reset is high, or on its assertion at any time (including mid-stream): result = 0, zero = 1, out_valid = 0. The in-flight operation is discarded.
- Combinational operation decode on alu_control:
  - 4'b0000: a AND b (bitwise).
  - 4'b0001: a OR b (bitwise).
  - 4'b0010: a + b, modulo 2^N. Carry-out is dropped.
  - 4'b0110: a - b, modulo 2^N, two's complement. A negative difference wraps, e.g. 0x569B - 0xB858 = 0xFFFF_FFFF_FFFF_9E43 for N = 64.
  - 4'b0111: pass b unchanged; a is ignored.
  - Any other code: result 0.
- zero is computed from the N-bit result before registering: zero = (result == 0). It is independent of operation type.
- Latency is 1 cycle.
  - On a rising clk edge with in_valid = 1: result and zero load the computed values and out_valid goes to 1.
  - On an edge with in_valid = 0: result and zero hold their previous values and out_valid goes to 0.
- Back-to-back operation is supported: a new operation can be accepted every cycle, with no stall or backpressure.
- Operations treat operands as unsigned bit vectors. There are no overflow or carry outputs, and no exceptions.
- There is no X-propagation masking; inputs are sampled only when in_valid = 1.

Test Plan:
- Reset: assert reset asynchronously mid-stream with in_valid = 1 -> result = 0, zero = 1 and out_valid = 0 immediately, without waiting for a clk edge. Deassert, then apply a = 0xABC, b = 0xDEF, AND -> one cycle later result = 0x8AC, zero = 0, out_valid = 1.
- Logic ops:
  - AND 0x267B & 0x3D8 -> 0x258, zero 0.
  - AND 0x6D55 & 0x92AA -> 0x0, zero 1.
  - OR 0xA596 | 0x4EAA -> 0xEFBE, zero 0.
  - OR 0x4565 | 0xBA9A -> 0xFFFF.
  - OR 0 | 0 -> 0, zero 1.
- Add:
  - 0x967B + 0xC8A1 -> 0x15F1C.
  - 0xFFFF + 0xFFFF -> 0x1FFFE.
  - 0 + 0 -> 0, zero 1.
  - Wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0, zero 1.
- Subtract:
  - 0x4589 - 0x32A2 -> 0x12E7.
  - 0x569B - 0xB858 -> 0xFFFF_FFFF_FFFF_9E43, zero 0.
  - 0 - 0 -> 0, zero 1.
- Pass B and illegal codes:
  - Pass B, a = 0xD255, b = 0x42A4 -> 0x42A4, zero 0.
  - Pass B, a = 0x61BD, b = 0 -> 0, zero 1.
  - Code 4'b1111 -> result 0, zero 1.
- Valid handling: stream 15 back-to-back vectors with in_valid = 1 -> each result appears exactly one cycle later. Drop in_valid for one cycle -> out_valid = 0 and result/zero hold the last value.
